// File: rtl/div_ctrl.sv
// Control block that sits between the EX stage and an iterative divider: it
// latches the operands, handles the divide-by-zero and signed-overflow cases
// on its own, sequences the divider, and returns one write-back pulse.
module div_ctrl #(
  parameter int XLEN    = 8,
  parameter int TIMEOUT = 31
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic [4:0]      rd_i,
  input  logic            flush_i,
  output logic            div_en_o,
  output logic [XLEN-1:0] dividend_o,
  output logic [XLEN-1:0] divisor_o,
  output logic            signed_o,
  input  logic [XLEN-1:0] quotient_i,
  input  logic [XLEN-1:0] rem_i,
  input  logic            done_i,
  output logic            result_valid_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_o,
  output logic            stall_o,
  output logic            err_o
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [XLEN-1:0]  MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   dividend_q, dividend_d;
  logic [XLEN-1:0]   divisor_q, divisor_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [4:0]        rd_q, rd_d;
  logic              signed_q, signed_d;
  logic              rem_sel_q, rem_sel_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              accept;
  logic              unused_funct3;

  // funct3[2] only distinguishes the divide group from multiplies upstream.
  assign unused_funct3 = funct3_i[2];

  assign req_ready_o    = rst & (state_q == S_IDLE) & ~flush_i;
  assign accept         = req_valid_i & req_ready_o;
  assign div_en_o       = (state_q == S_ISSUE) | (state_q == S_WAIT);
  assign stall_o        = div_en_o | accept;
  assign result_valid_o = (state_q == S_DONE) & ~flush_i;
  assign dividend_o     = dividend_q;
  assign divisor_o      = divisor_q;
  assign signed_o       = signed_q;
  assign result_o       = result_q;
  assign rd_o           = rd_q;
  assign err_o          = err_q;

  always_comb begin
    state_d    = state_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    result_d   = result_q;
    rd_d       = rd_q;
    signed_d   = signed_q;
    rem_sel_d  = rem_sel_q;
    cnt_d      = cnt_q;
    err_d      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          dividend_d = rs1_i;
          divisor_d  = rs2_i;
          rd_d       = rd_i;
          signed_d   = ~funct3_i[0];
          rem_sel_d  = funct3_i[1];
          // Zero divisor is checked first so MIN/0 takes the divide-by-zero result.
          if (rs2_i == '0) begin
            result_d = funct3_i[1] ? rs1_i : '1;
            state_d  = S_DONE;
          end else if (!funct3_i[0] && (rs1_i == MIN_NEG) && (rs2_i == '1)) begin
            result_d = funct3_i[1] ? '0 : rs1_i;
            state_d  = S_DONE;
          end else begin
            state_d  = S_ISSUE;
          end
        end
      end

      S_ISSUE: begin
        if (flush_i) begin
          state_d = S_IDLE;
        end else begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (flush_i) begin
          state_d = S_IDLE;
        end else if (done_i) begin
          result_d = rem_sel_q ? rem_i : quotient_i;
          state_d  = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      dividend_q <= '0;
      divisor_q  <= '0;
      result_q   <= '0;
      rd_q       <= '0;
      signed_q   <= 1'b0;
      rem_sel_q  <= 1'b0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      result_q   <= result_d;
      rd_q       <= rd_d;
      signed_q   <= signed_d;
      rem_sel_q  <= rem_sel_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: doc/div_ctrl.md
DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default 8, operand and result width in bits.
REQ-002 SHALL have parameter TIMEOUT, default 31, maximum WAIT cycles before abort.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-005 SHALL have port req_valid_i  input  1  EX-stage divide request present.
REQ-006 SHALL have port req_ready_o  output  1  block can accept a request this cycle.
REQ-007 SHALL have port funct3_i  input  3  100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-008 SHALL have port rs1_i  input  XLEN  dividend.
REQ-009 SHALL have port rs2_i  input  XLEN  divisor.
REQ-010 SHALL have port rd_i  input  5  destination register index.
REQ-011 SHALL have port flush_i  input  1  pipeline flush; abort any operation.
REQ-012 SHALL have port div_en_o  output  1  divider enable (divider div_en).
REQ-013 SHALL have port dividend_o  output  XLEN  registered dividend to the divider.
REQ-014 SHALL have port divisor_o  output  XLEN  registered divisor to the divider.
REQ-015 SHALL have port signed_o  output  1  signed operation (funct3[0]==0).
REQ-016 SHALL have port quotient_i  input  XLEN  divider quotient.
REQ-017 SHALL have port rem_i  input  XLEN  divider remainder.
REQ-018 SHALL have port done_i  input  1  divider result valid (divider wd_en).
REQ-019 SHALL have port result_valid_o  output  1  one-cycle write-back pulse.
REQ-020 SHALL have port result_o  output  XLEN  write-back data.
REQ-021 SHALL have port rd_o  output  5  write-back register index.
REQ-022 SHALL have port stall_o  output  1  holds upstream pipeline while busy.
REQ-023 SHALL have port err_o  output  1  one-cycle pulse on timeout.

Function
REQ-024 SHALL implement states IDLE, ISSUE, WAIT, DONE.
REQ-025 SHALL drive req_ready_o=1 only in IDLE with flush_i=0; accept = req_valid_i & req_ready_o.
REQ-026 On accept SHALL register rs1_i, rs2_i, funct3_i, rd_i; these SHALL NOT change until return to IDLE.
REQ-027 Special case divisor==0: SHALL go to DONE next cycle, never assert div_en_o; quotient all-ones, remainder = dividend.
REQ-028 Special case signed, dividend==1<<(XLEN-1), divisor all-ones: SHALL go to DONE next cycle, no div_en_o; quotient = dividend, remainder 0.
REQ-029 Divisor-zero check SHALL take priority over overflow check.
REQ-030 Otherwise accept SHALL go to ISSUE; div_en_o=1 in ISSUE and WAIT only.
REQ-031 ISSUE SHALL last exactly one cycle, then WAIT; done_i SHALL be ignored in IDLE and ISSUE (stale divider done).
REQ-032 In WAIT, done_i=1 SHALL capture quotient_i/rem_i, drop div_en_o next cycle, go to DONE.
REQ-033 result_o SHALL select remainder when funct3[1]=1, else quotient.
REQ-034 In DONE SHALL assert result_valid_o for exactly one cycle with result_o, rd_o, then go to IDLE.
REQ-035 stall_o SHALL be 1 in ISSUE, WAIT, and in the accept cycle; 0 in DONE and IDLE otherwise.
REQ-036 WAIT cycle counter SHALL reset on entry; on reaching TIMEOUT without done_i SHALL pulse err_o, drop div_en_o, go to IDLE, no result_valid_o.
REQ-037 flush_i=1 in ISSUE/WAIT/DONE SHALL go to IDLE next cycle, suppress result_valid_o, drop div_en_o.
REQ-038 flush_i=1 with req_valid_i=1 in IDLE: flush SHALL win, no accept.
REQ-039 done_i and flush_i same WAIT cycle: flush SHALL win.
REQ-040 Back-to-back: a new request SHALL be accepted no earlier than the cycle after DONE.

Reset
REQ-041 rst=0 at a rising edge SHALL force IDLE and clear div_en_o, result_valid_o, stall_o, err_o, result_o, rd_o, dividend_o, divisor_o, signed_o, counter to 0.
REQ-042 Reset mid-operation SHALL abandon it with no result_valid_o; req_ready_o=1 the first cycle after rst returns high.

Verification
REQ-043 DIVU rs1=200 rs2=7, divider model returns 28/4 -> result_valid_o once, result_o=28, rd_o=rd_i.
REQ-044 REM rs1=0xF9 rs2=0x02, model returns q=0xFD r=0xFF -> result_o=0xFF, signed_o=1 throughout.
REQ-045 DIV rs1=0x25 rs2=0 -> result_o=0xFF one cycle after accept, div_en_o never 1; REMU same operands -> 0x25.
REQ-046 DIV rs1=0x80 rs2=0xFF -> result_o=0x80; REM -> 0x00; div_en_o never 1.
REQ-047 Flush in 3rd WAIT cycle, then done_i -> no result_valid_o, div_en_o 0 next cycle, req_ready_o 1.
REQ-048 done_i held 0 -> err_o pulses after 31 WAIT cycles, IDLE; done_i=1 held from before accept -> ignored until WAIT.
